// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the functional units and the CDB arbiter.
// The slave modport is the arbiter side; the master modport is the FU/consumer side.
interface cdb_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) ();

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*TAG_W-1:0]  req_tag_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    cdb_hold_i;
  logic                    cdb_en_o;
  logic [TAG_W-1:0]        cdb_tag_o;
  logic [DATA_W-1:0]       cdb_data_o;
  logic [1:0]              cdb_src_o;
  logic [N_REQ-1:0]        pending_o;

  modport slave (
    input  req_valid_i,
    input  req_tag_i,
    input  req_data_i,
    input  cdb_hold_i,
    output req_ready_o,
    output cdb_en_o,
    output cdb_tag_o,
    output cdb_data_o,
    output cdb_src_o,
    output pending_o
  );

  modport master (
    output req_valid_i,
    output req_tag_i,
    output req_data_i,
    output cdb_hold_i,
    input  req_ready_o,
    input  cdb_en_o,
    input  cdb_tag_o,
    input  cdb_data_o,
    input  cdb_src_o,
    input  pending_o
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one holding register per FU, one registered broadcast per cycle.
// Optional macro CDB_FLUSH_EN adds flush_i, which empties all holding registers and kills the broadcast.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
`ifdef CDB_FLUSH_EN
  input  logic         flush_i,
`endif
  cdb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = 2;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t             slot_q [N_REQ];
  slot_t             slot_d [N_REQ];
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_en_q, cdb_en_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [PTR_W-1:0]  cdb_src_q, cdb_src_d;

  logic [N_REQ-1:0]  elig_c;
  logic [N_REQ-1:0]  grant_c;
  logic [N_REQ-1:0]  ready_c;
  logic [N_REQ-1:0]  capture_c;
  logic              win_valid_c;
  logic              fire_c;
  logic [PTR_W-1:0]  win_idx_c;

  // Round-robin pick: first pass from rr_ptr upward, second pass wraps to the bottom.
  always_comb begin
    elig_c      = bus.cdb_hold_i ? '0 : pending_q;
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    grant_c     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_valid_c && elig_c[PTR_W'(i)] && (PTR_W'(i) >= rr_ptr_q)) begin
        win_valid_c = 1'b1;
        win_idx_c   = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_valid_c && elig_c[PTR_W'(i)]) begin
        win_valid_c = 1'b1;
        win_idx_c   = PTR_W'(i);
      end
    end
    if (win_valid_c) begin
      grant_c[win_idx_c] = 1'b1;
    end
  end

  // A slot being granted this cycle can be refilled on the same edge.
`ifdef CDB_FLUSH_EN
  assign ready_c = (~pending_q | grant_c) & {N_REQ{~flush_i}};
  assign fire_c  = win_valid_c & ~flush_i;
`else
  assign ready_c = ~pending_q | grant_c;
  assign fire_c  = win_valid_c;
`endif
  assign capture_c = bus.req_valid_i & ready_c;

  // Next-state: holding-register fill/drain, broadcast register, pointer advance.
  always_comb begin
    pending_d  = pending_q & ~grant_c;
    slot_d     = slot_q;
    cdb_en_d   = fire_c;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    rr_ptr_d   = rr_ptr_q;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (capture_c[PTR_W'(i)]) begin
        pending_d[PTR_W'(i)]   = 1'b1;
        slot_d[PTR_W'(i)].tag  = bus.req_tag_i[i*TAG_W +: TAG_W];
        slot_d[PTR_W'(i)].data = bus.req_data_i[i*DATA_W +: DATA_W];
      end
    end

    if (fire_c) begin
      cdb_tag_d  = slot_q[win_idx_c].tag;
      cdb_data_d = slot_q[win_idx_c].data;
      cdb_src_d  = win_idx_c;
      rr_ptr_d   = (win_idx_c == LAST_IDX) ? '0 : win_idx_c + PTR_W'(1);
    end

`ifdef CDB_FLUSH_EN
    if (flush_i) begin
      pending_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      cdb_en_q   <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        slot_q[PTR_W'(i)] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        slot_q[PTR_W'(i)] <= slot_d[PTR_W'(i)];
      end
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.cdb_en_o    = cdb_en_q;
  assign bus.cdb_tag_o   = cdb_tag_q;
  assign bus.cdb_data_o  = cdb_data_q;
  assign bus.cdb_src_o   = cdb_src_q;
  assign bus.pending_o   = pending_q;

  a_grant_onehot : assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_c));
  a_hold_no_grant : assert property (@(posedge clk_i) disable iff (reset_i) bus.cdb_hold_i |-> (grant_c == '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a per-FU slot/pointer reference model.
// Define CDB_FLUSH_EN to also exercise the flush path.
module tb_cdb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
`ifdef CDB_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one held entry per FU, a rotating start index, the last broadcast.
  bit          m_pend [N];
  logic [TW-1:0] m_tag [N];
  logic [DW-1:0] m_data [N];
  int          m_rr;
  logic        e_en;
  logic [TW-1:0] e_tag;
  logic [DW-1:0] e_data;
  int          e_src;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_tag[k]  = '0;
      m_data[k] = '0;
    end
    m_rr   = 0;
    e_en   = 1'b0;
    e_tag  = '0;
    e_data = '0;
    e_src  = 0;
  endtask

  function automatic int pick();
    if (bus.cdb_hold_i || flush) return -1;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_rr + off) % N;
      if (m_pend[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic set_req(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.req_valid_i[k]          = 1'b1;
    bus.req_tag_i[k*TW +: TW]   = t;
    bus.req_data_i[k*DW +: DW]  = d;
  endtask

  task automatic clear_req(input int k);
    bus.req_valid_i[k] = 1'b0;
  endtask

  // One clock: check readiness before the edge, advance the model, check registered outputs after.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    #1;
    w = pick();
    for (int k = 0; k < N; k++) exp_rdy[k] = !flush && (!m_pend[k] || (w == k));
    check("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
    @(posedge clk);
    if (w >= 0) begin
      e_en      = 1'b1;
      e_tag     = m_tag[w];
      e_data    = m_data[w];
      e_src     = w;
      m_pend[w] = 1'b0;
      m_rr      = (w + 1) % N;
    end else begin
      e_en = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid_i[k] && exp_rdy[k]) begin
        m_pend[k] = 1'b1;
        m_tag[k]  = bus.req_tag_i[k*TW +: TW];
        m_data[k] = bus.req_data_i[k*DW +: DW];
      end
    end
    if (flush) for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
    #1;
    check("cdb_en", 64'(bus.cdb_en_o), 64'(e_en));
    check("cdb_tag", 64'(bus.cdb_tag_o), 64'(e_tag));
    check("cdb_data", 64'(bus.cdb_data_o), 64'(e_data));
    check("cdb_src", 64'(bus.cdb_src_o), 64'(e_src));
    check("pending", 64'(bus.pending_o), 64'(model_pending()));
  endtask

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_tag_i    = '0;
    bus.req_data_i   = '0;
    bus.cdb_hold_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 64'(bus.cdb_en_o), 64'(0));
    check("rst_pending", 64'(bus.pending_o), 64'(0));
    check("rst_ready", 64'(bus.req_ready_o), 64'(3'b111));
    rst = 1'b0;

    // Single ALU result.
    set_req(0, 5'd7, 32'hDEADBEEF);
    step();
    check("alu_pend", 64'(bus.pending_o), 64'(3'b001));
    clear_req(0);
    step();
    check("alu_en", 64'(bus.cdb_en_o), 64'(1));
    check("alu_tag", 64'(bus.cdb_tag_o), 64'(7));
    check("alu_data", 64'(bus.cdb_data_o), 64'(32'hDEADBEEF));
    check("alu_src", 64'(bus.cdb_src_o), 64'(0));
    check("alu_pend0", 64'(bus.pending_o), 64'(0));
    step();

    // Mid-operation async reset discards held results and broadcast.
    for (int k = 0; k < N; k++) set_req(k, TW'($urandom), $urandom);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_en", 64'(bus.cdb_en_o), 64'(0));
    check("arst_pending", 64'(bus.pending_o), 64'(0));
    check("arst_ready", 64'(bus.req_ready_o), 64'(3'b111));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // All requesters continuously valid from reset: strict rotation.
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < N; k++) set_req(k, TW'($urandom), $urandom);
      step();
      if (i >= 1) begin
        check("rr_en", 64'(bus.cdb_en_o), 64'(1));
        check("rr_src", 64'(bus.cdb_src_o), 64'((i - 1) % 3));
      end
    end
    for (int k = 0; k < N; k++) clear_req(k);
    repeat (4) step();

    // Stall with MUL pending.
    set_req(1, 5'd12, 32'h1234_5678);
    bus.cdb_hold_i = 1'b1;
    step();
    clear_req(1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_en", 64'(bus.cdb_en_o), 64'(0));
      check("hold_ready1", 64'(bus.req_ready_o[1]), 64'(0));
    end
    bus.cdb_hold_i = 1'b0;
    step();
    check("unhold_en", 64'(bus.cdb_en_o), 64'(1));
    check("unhold_tag", 64'(bus.cdb_tag_o), 64'(12));
    check("unhold_src", 64'(bus.cdb_src_o), 64'(1));

    // Same-cycle refill on LSU.
    set_req(2, 5'd3, 32'hAAAA_0003);
    step();
    set_req(2, 5'd9, 32'hBBBB_0009);
    step();
    check("refill_tag", 64'(bus.cdb_tag_o), 64'(3));
    check("refill_pend2", 64'(bus.pending_o[2]), 64'(1));
    clear_req(2);
    step();
    check("refill_next_tag", 64'(bus.cdb_tag_o), 64'(9));
    check("refill_next_src", 64'(bus.cdb_src_o), 64'(2));

    // Tag zero is an ordinary tag.
    set_req(0, 5'd0, 32'h0000_0F0F);
    step();
    clear_req(0);
    step();
    check("tag0_en", 64'(bus.cdb_en_o), 64'(1));
    check("tag0_tag", 64'(bus.cdb_tag_o), 64'(0));

`ifdef CDB_FLUSH_EN
    // Flush with ALU and LSU held.
    bus.cdb_hold_i = 1'b1;
    set_req(0, 5'd4, 32'h4);
    set_req(2, 5'd6, 32'h6);
    step();
    clear_req(0);
    clear_req(2);
    bus.cdb_hold_i = 1'b0;
    flush = 1'b1;
    step();
    check("flush_pending", 64'(bus.pending_o), 64'(0));
    check("flush_en", 64'(bus.cdb_en_o), 64'(0));
    flush = 1'b0;
    set_req(0, 5'd4, 32'h4);
    set_req(2, 5'd6, 32'h6);
    step();
    clear_req(0);
    clear_req(2);
    repeat (3) step();
`endif

    // Randomized traffic with stalls.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 99) < 60) set_req(k, TW'($urandom), $urandom);
        else clear_req(k);
      end
      bus.cdb_hold_i = ($urandom_range(0, 4) == 0);
`ifdef CDB_FLUSH_EN
      flush = ($urandom_range(0, 19) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
